trap_ctrl: RTL and testbench

- Trap sequencer that sits directly upstream of the machine-mode CSR file.
- Arbitrates synchronous exceptions, machine interrupts (external, software, timer) and MRET.
- Drains the pipeline, then produces the interrupt_enter/exit pulses, cause, mepc and mtval values the CSR file latches.
- Issues the PC redirect to fetch, computed from mtvec (direct/vectored) or mepc.

---
 rtl/rv_trap_pkg.sv | 23 ++
 rtl/trap_prio_enc.sv | 54 +++++
 rtl/trap_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_trap_pkg.sv
// Shared trap-sequencer types: FSM states, mcause codes, mtvec modes.
package rv_trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ENTER,
        ST_RDRAIN,
        ST_RETURN,
        ST_SETTLE
    } trap_state_e;

    localparam int CAUSE_MSI = 3;
    localparam int CAUSE_MTI = 7;
    localparam int CAUSE_MEI = 11;
    localparam int INT_BIT   = 31;

    typedef enum logic [1:0] {
        MODE_DIRECT   = 2'b00,
        MODE_VECTORED = 2'b01
    } tvec_mode_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Exception/interrupt eligibility and fixed-priority encoder.
// Exception beats ext > soft > timer interrupts.
module trap_prio_enc
    import rv_trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_code,
    input  logic            i_mstatus_mie,
    input  logic [XLEN-1:0] i_mie,
    input  logic            i_irq_ext,
    input  logic            i_irq_soft,
    input  logic            i_irq_timer,
    output logic            o_take,
    output logic            o_is_int,
    output logic [3:0]      o_code
);

    logic w_ext;
    logic w_soft;
    logic w_timer;
    logic w_unused;

    assign w_ext   = i_mstatus_mie & i_mie[CAUSE_MEI] & i_irq_ext;
    assign w_soft  = i_mstatus_mie & i_mie[CAUSE_MSI] & i_irq_soft;
    assign w_timer = i_mstatus_mie & i_mie[CAUSE_MTI] & i_irq_timer;

    assign w_unused = ^{i_mie[XLEN-1:12], i_mie[10:8],
                        i_mie[6:4], i_mie[2:0]};

    always_comb begin
        o_take   = 1'b0;
        o_is_int = 1'b0;
        o_code   = 4'd0;
        if (i_exc_valid) begin
            o_take = 1'b1;
            o_code = i_exc_code;
        end else if (w_ext) begin
            o_take   = 1'b1;
            o_is_int = 1'b1;
            o_code   = 4'(CAUSE_MEI);
        end else if (w_soft) begin
            o_take   = 1'b1;
            o_is_int = 1'b1;
            o_code   = 4'(CAUSE_MSI);
        end else if (w_timer) begin
            o_take   = 1'b1;
            o_is_int = 1'b1;
            o_code   = 4'(CAUSE_MTI);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: drains the pipe, pulses CSR enter/exit, redirects fetch.
// Define TRAP_CTRL_NMI_EN to add the edge-triggered i_nmi input.
module trap_ctrl
    import rv_trap_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] NMI_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_mstatus_mie,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_irq_ext,
    input  logic            i_irq_soft,
    input  logic            i_irq_timer,
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_code,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_commit_pc,
    input  logic            i_pipe_idle,
`ifdef TRAP_CTRL_NMI_EN
    input  logic            i_nmi,
`endif
    output logic            o_flush,
    output logic            o_int_enter,
    output logic            o_int_exit,
    output logic [XLEN-1:0] o_int_cause,
    output logic [XLEN-1:0] o_int_pc,
    output logic [XLEN-1:0] o_int_mtval,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy
);

    trap_state_e     r_state;
    trap_state_e     w_nxt;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_tval;
    logic            r_is_int;
    logic            r_flush;
    logic            r_enter;
    logic            r_exit;
    logic            r_redir_v;
    logic            r_busy;
    logic [XLEN-1:0] r_o_cause;
    logic [XLEN-1:0] r_o_pc;
    logic [XLEN-1:0] r_o_tval;
    logic [XLEN-1:0] r_redir_pc;

    logic            w_take;
    logic            w_is_int;
    logic [3:0]      w_code;
    logic            w_lat;
    logic [XLEN-1:0] w_lat_cause;
    logic [XLEN-1:0] w_lat_pc;
    logic [XLEN-1:0] w_lat_tval;
    logic            w_lat_int;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec;
    logic [XLEN-1:0] w_tgt;
    logic            w_unused;

`ifdef TRAP_CTRL_NMI_EN
    logic r_nmi_q;
    logic r_nmi_pend;
    logic r_nmi;
    logic w_lat_nmi;
`endif

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .i_exc_valid   (i_exc_valid),
        .i_exc_code    (i_exc_code),
        .i_mstatus_mie (i_mstatus_mie),
        .i_mie         (i_mie),
        .i_irq_ext     (i_irq_ext),
        .i_irq_soft    (i_irq_soft),
        .i_irq_timer   (i_irq_timer),
        .o_take        (w_take),
        .o_is_int      (w_is_int),
        .o_code        (w_code)
    );

    always_comb begin
        w_nxt       = r_state;
        w_lat       = 1'b0;
        w_lat_cause = '0;
        w_lat_pc    = '0;
        w_lat_tval  = '0;
        w_lat_int   = 1'b0;
`ifdef TRAP_CTRL_NMI_EN
        w_lat_nmi   = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
`ifdef TRAP_CTRL_NMI_EN
                if (r_nmi_pend) begin
                    w_nxt                = ST_DRAIN;
                    w_lat                = 1'b1;
                    w_lat_cause[INT_BIT] = 1'b1;
                    w_lat_int            = 1'b1;
                    w_lat_nmi            = 1'b1;
                end else
`endif
                if (w_take && !w_is_int) begin
                    w_nxt       = ST_DRAIN;
                    w_lat       = 1'b1;
                    w_lat_cause = XLEN'(w_code);
                    w_lat_pc    = i_exc_pc;
                    w_lat_tval  = i_exc_tval;
                end else if (i_mret) begin
                    w_nxt = ST_RDRAIN;
                end else if (w_take) begin
                    w_nxt                = ST_DRAIN;
                    w_lat                = 1'b1;
                    w_lat_cause[INT_BIT] = 1'b1;
                    w_lat_cause[3:0]     = w_code;
                    w_lat_int            = 1'b1;
                end
            end
            ST_DRAIN:  if (i_pipe_idle) w_nxt = ST_ENTER;
            ST_ENTER:  w_nxt = ST_SETTLE;
            ST_RDRAIN: if (i_pipe_idle) w_nxt = ST_RETURN;
            ST_RETURN: w_nxt = ST_SETTLE;
            ST_SETTLE: w_nxt = ST_IDLE;
            default:   w_nxt = ST_IDLE;
        endcase
    end

    // Only interrupts are vectored; reserved modes fall back to direct.
    assign w_base = {i_mtvec[XLEN-1:2], 2'b00};
    assign w_vec  = w_base + {{(XLEN-6){1'b0}}, r_cause[3:0], 2'b00};

    always_comb begin
        w_tgt = w_base;
        if (r_is_int && i_mtvec[1:0] == MODE_VECTORED)
            w_tgt = w_vec;
`ifdef TRAP_CTRL_NMI_EN
        if (r_nmi)
            w_tgt = NMI_VEC;
`endif
    end

    assign w_unused = ^i_mepc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cause    <= '0;
            r_pc       <= '0;
            r_tval     <= '0;
            r_is_int   <= 1'b0;
            r_flush    <= 1'b0;
            r_enter    <= 1'b0;
            r_exit     <= 1'b0;
            r_redir_v  <= 1'b0;
            r_busy     <= 1'b0;
            r_o_cause  <= '0;
            r_o_pc     <= '0;
            r_o_tval   <= '0;
            r_redir_pc <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_lat) begin
                r_cause  <= w_lat_cause;
                r_pc     <= w_lat_pc;
                r_tval   <= w_lat_tval;
                r_is_int <= w_lat_int;
            end
            if (r_state == ST_DRAIN && i_pipe_idle && r_is_int)
                r_pc <= i_commit_pc;
            r_flush   <= (w_nxt == ST_DRAIN) || (w_nxt == ST_RDRAIN);
            r_enter   <= (w_nxt == ST_ENTER);
            r_exit    <= (w_nxt == ST_RETURN);
            r_redir_v <= (w_nxt == ST_ENTER) || (w_nxt == ST_RETURN);
            r_busy    <= (w_nxt != ST_IDLE);
            if (w_nxt == ST_ENTER) begin
                r_o_cause  <= r_cause;
                r_o_pc     <= r_is_int ? i_commit_pc : r_pc;
                r_o_tval   <= r_tval;
                r_redir_pc <= w_tgt;
            end
            if (w_nxt == ST_RETURN)
                r_redir_pc <= {i_mepc[XLEN-1:2], 2'b00};
        end
    end

`ifdef TRAP_CTRL_NMI_EN
    // A fresh edge wins over the clear so a back-to-back NMI is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_q    <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_nmi      <= 1'b0;
        end else begin
            r_nmi_q <= i_nmi;
            if (i_nmi && !r_nmi_q)
                r_nmi_pend <= 1'b1;
            else if (r_nmi && w_nxt == ST_ENTER)
                r_nmi_pend <= 1'b0;
            if (w_lat)
                r_nmi <= w_lat_nmi;
        end
    end
`endif

    assign o_flush          = r_flush;
    assign o_int_enter      = r_enter;
    assign o_int_exit       = r_exit;
    assign o_int_cause      = r_o_cause;
    assign o_int_pc         = r_o_pc;
    assign o_int_mtval      = r_o_tval;
    assign o_redirect_valid = r_redir_v;
    assign o_redirect_pc    = r_redir_pc;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table, random model, corner sequences.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mstatus_mie;
    logic [31:0] i_mie;
    logic [31:0] i_mtvec;
    logic [31:0] i_mepc;
    logic        i_irq_ext;
    logic        i_irq_soft;
    logic        i_irq_timer;
    logic        i_exc_valid;
    logic [3:0]  i_exc_code;
    logic [31:0] i_exc_pc;
    logic [31:0] i_exc_tval;
    logic        i_mret;
    logic [31:0] i_commit_pc;
    logic        i_pipe_idle;
    logic        o_flush;
    logic        o_int_enter;
    logic        o_int_exit;
    logic [31:0] o_int_cause;
    logic [31:0] o_int_pc;
    logic [31:0] o_int_mtval;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        o_busy;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_mstatus_mie    (i_mstatus_mie),
        .i_mie            (i_mie),
        .i_mtvec          (i_mtvec),
        .i_mepc           (i_mepc),
        .i_irq_ext        (i_irq_ext),
        .i_irq_soft       (i_irq_soft),
        .i_irq_timer      (i_irq_timer),
        .i_exc_valid      (i_exc_valid),
        .i_exc_code       (i_exc_code),
        .i_exc_pc         (i_exc_pc),
        .i_exc_tval       (i_exc_tval),
        .i_mret           (i_mret),
        .i_commit_pc      (i_commit_pc),
        .i_pipe_idle      (i_pipe_idle),
        .o_flush          (o_flush),
        .o_int_enter      (o_int_enter),
        .o_int_exit       (o_int_exit),
        .o_int_cause      (o_int_cause),
        .o_int_pc         (o_int_pc),
        .o_int_mtval      (o_int_mtval),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_busy           (o_busy)
    );

    typedef struct {
        logic        exc;
        logic [3:0]  code;
        logic [31:0] epc;
        logic [31:0] tval;
        logic        mret;
        logic        gie;
        logic [31:0] mie;
        logic        ext;
        logic        sft;
        logic        tmr;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] cpc;
        int          drain;
        int          kind;
        logic [31:0] x_cause;
        logic [31:0] x_pc;
        logic [31:0] x_tval;
        logic [31:0] x_redir;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        i_mstatus_mie = 1'b0;
        i_mie         = '0;
        i_mtvec       = '0;
        i_mepc        = '0;
        i_irq_ext     = 1'b0;
        i_irq_soft    = 1'b0;
        i_irq_timer   = 1'b0;
        i_exc_valid   = 1'b0;
        i_exc_code    = '0;
        i_exc_pc      = '0;
        i_exc_tval    = '0;
        i_mret        = 1'b0;
        i_commit_pc   = '0;
        i_pipe_idle   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decide the trap directly from the architectural rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          order[3];
        logic        pend;
        logic        found;
        logic [31:0] base;
        r        = v;
        order    = '{11, 3, 7};
        found    = 1'b0;
        base     = v.mtvec & ~32'h3;
        r.kind   = 0;
        r.x_cause = '0;
        r.x_pc    = '0;
        r.x_tval  = '0;
        r.x_redir = '0;
        if (v.exc) begin
            r.kind    = 1;
            r.x_cause = {28'b0, v.code};
            r.x_pc    = v.epc;
            r.x_tval  = v.tval;
            r.x_redir = base;
        end else if (v.mret) begin
            r.kind    = 2;
            r.x_redir = v.mepc & ~32'h3;
        end else if (v.gie) begin
            for (int i = 0; i < 3; i++) begin
                pend = (order[i] == 11) ? v.ext :
                       (order[i] == 3)  ? v.sft : v.tmr;
                if (!found && pend && v.mie[order[i]]) begin
                    found     = 1'b1;
                    r.kind    = 1;
                    r.x_cause = 32'h8000_0000 + order[i];
                    r.x_pc    = v.cpc;
                    r.x_tval  = '0;
                    r.x_redir = (v.mtvec[1:0] == 2'b01) ?
                                base + 32'(4 * order[i]) : base;
                end
            end
        end
        return r;
    endfunction

    task automatic apply(input vec_t v);
        int n;
        int fl;
        int xfl;
        i_exc_valid   = v.exc;
        i_exc_code    = v.code;
        i_exc_pc      = v.epc;
        i_exc_tval    = v.tval;
        i_mret        = v.mret;
        i_mstatus_mie = v.gie;
        i_mie         = v.mie;
        i_irq_ext     = v.ext;
        i_irq_soft    = v.sft;
        i_irq_timer   = v.tmr;
        i_mtvec       = v.mtvec;
        i_mepc        = v.mepc;
        i_commit_pc   = v.cpc;
        i_pipe_idle   = (v.drain == 0);
        tick();
        i_exc_valid = 1'b0;
        i_mret      = 1'b0;
        i_irq_ext   = 1'b0;
        i_irq_soft  = 1'b0;
        i_irq_timer = 1'b0;
        if (v.kind == 0) begin
            chk1("idle_flush", o_flush, 1'b0);
            chk1("idle_busy", o_busy, 1'b0);
            tick();
            chk1("idle_busy2", o_busy, 1'b0);
            clear_in();
            return;
        end
        fl = 0;
        n  = 0;
        while (!(o_int_enter || o_int_exit) && n < 20) begin
            if (o_flush) fl++;
            n++;
            if (n >= v.drain) i_pipe_idle = 1'b1;
            tick();
        end
        if (n >= 20) begin
            errors++;
            checks++;
            $display("FAIL timeout: no enter/exit after %0d cycles", n);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            clear_in();
            return;
        end
        xfl = (v.drain == 0) ? 1 : v.drain;
        chk("flush_cycles", 32'(fl), 32'(xfl));
        chk1("enter", o_int_enter, v.kind == 1);
        chk1("exit", o_int_exit, v.kind == 2);
        chk1("redir_valid", o_redirect_valid, 1'b1);
        chk1("flush_at_pulse", o_flush, 1'b0);
        chk("redir_pc", o_redirect_pc, v.x_redir);
        if (v.kind == 1) begin
            chk("cause", o_int_cause, v.x_cause);
            chk("mepc", o_int_pc, v.x_pc);
            chk("mtval", o_int_mtval, v.x_tval);
        end
        tick();
        chk1("settle_busy", o_busy, 1'b1);
        chk1("settle_pulse", o_int_enter | o_int_exit | o_redirect_valid, 1'b0);
        tick();
        chk1("back_idle", o_busy, 1'b0);
        clear_in();
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        // exc code pc tval mret gie mie ext sft tmr mtvec mepc cpc drain | kind cause pc tval redir
        tbl[0] = '{1'b1, 4'd2, 32'h80, 32'hDEAD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
                   32'h1000, 32'h0, 32'h0, 0, 1, 32'h2, 32'h80, 32'hDEAD, 32'h1000};
        tbl[1] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1,
                   32'h1001, 32'h0, 32'h200, 0, 1, 32'h8000_0007, 32'h200, 32'h0, 32'h101C};
        tbl[2] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h888, 1'b1, 1'b1, 1'b1,
                   32'h1001, 32'h0, 32'h300, 0, 1, 32'h8000_000B, 32'h300, 32'h0, 32'h102C};
        tbl[3] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h888, 1'b1, 1'b1, 1'b1,
                   32'h1001, 32'h0, 32'h300, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 4'd5, 32'h44, 32'h7, 1'b1, 1'b1, 32'h888, 1'b1, 1'b0, 1'b0,
                   32'h2003, 32'h344, 32'h0, 1, 1, 32'h5, 32'h44, 32'h7, 32'h2000};
        tbl[5] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h800, 1'b1, 1'b0, 1'b0,
                   32'h1000, 32'h0, 32'h400, 5, 1, 32'h8000_000B, 32'h400, 32'h0, 32'h1000};
        tbl[6] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
                   32'h1000, 32'h344, 32'h0, 0, 2, 32'h0, 32'h0, 32'h0, 32'h344};
        tbl[7] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1,
                   32'h1000, 32'h347, 32'h0, 3, 2, 32'h0, 32'h0, 32'h0, 32'h344};
        tbl[8] = '{1'b1, 4'd11, 32'h90, 32'h1, 1'b0, 1'b1, 32'h888, 1'b0, 1'b0, 1'b1,
                   32'h1001, 32'h0, 32'h0, 0, 1, 32'hB, 32'h90, 32'h1, 32'h1000};
        tbl[9] = '{1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h888, 1'b0, 1'b1, 1'b1,
                   32'h1001, 32'h0, 32'h600, 2, 1, 32'h8000_0003, 32'h600, 32'h0, 32'h100C};

        clear_in();
        rst = 1'b1;
        repeat (3) tick();
        chk1("rst_flush", o_flush, 1'b0);
        chk1("rst_enter", o_int_enter, 1'b0);
        chk1("rst_exit", o_int_exit, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_rv", o_redirect_valid, 1'b0);
        chk("rst_cause", o_int_cause, 32'h0);
        chk("rst_pc", o_int_pc, 32'h0);
        chk("rst_redir", o_redirect_pc, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) apply(tbl[i]);

        // Interrupt pending through MRET/SETTLE is taken only from IDLE.
        clear_in();
        i_mstatus_mie = 1'b1;
        i_mie         = 32'h80;
        i_irq_timer   = 1'b1;
        i_mret        = 1'b1;
        i_mepc        = 32'h344;
        i_mtvec       = 32'h1000;
        i_commit_pc   = 32'h500;
        tick();
        chk1("sq_rdrain", o_flush, 1'b1);
        i_mret = 1'b0;
        tick();
        chk1("sq_exit", o_int_exit, 1'b1);
        chk("sq_ret_pc", o_redirect_pc, 32'h344);
        tick();
        chk1("sq_settle_flush", o_flush, 1'b0);
        chk1("sq_settle_busy", o_busy, 1'b1);
        tick();
        chk1("sq_idle_flush", o_flush, 1'b0);
        chk1("sq_idle_busy", o_busy, 1'b0);
        tick();
        chk1("sq_drain", o_flush, 1'b1);
        i_irq_timer = 1'b0;
        tick();
        chk1("sq_enter", o_int_enter, 1'b1);
        chk("sq_cause", o_int_cause, 32'h8000_0007);
        chk("sq_pc", o_int_pc, 32'h500);
        tick();
        tick();
        chk1("sq_done", o_busy, 1'b0);

        // Reset in DRAIN aborts without an entry pulse.
        clear_in();
        i_exc_valid = 1'b1;
        i_exc_code  = 4'd3;
        i_exc_pc    = 32'h10;
        i_pipe_idle = 1'b0;
        tick();
        chk1("rd_flush", o_flush, 1'b1);
        i_exc_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk1("rd_flush0", o_flush, 1'b0);
        chk1("rd_busy0", o_busy, 1'b0);
        chk1("rd_rv0", o_redirect_valid, 1'b0);
        chk("rd_cause0", o_int_cause, 32'h0);
        chk("rd_pc0", o_int_pc, 32'h0);
        chk("rd_tval0", o_int_mtval, 32'h0);
        chk("rd_redir0", o_redirect_pc, 32'h0);
        rst = 1'b0;
        i_pipe_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rd_no_enter", o_int_enter, 1'b0);
            chk1("rd_no_busy", o_busy, 1'b0);
        end

        for (int i = 0; i < 60; i++) begin
            rv.exc   = ($urandom_range(0, 3) == 0);
            rv.code  = 4'($urandom);
            rv.epc   = $urandom;
            rv.tval  = $urandom;
            rv.mret  = ($urandom_range(0, 3) == 0);
            rv.gie   = 1'($urandom_range(0, 1));
            rv.mie   = $urandom;
            rv.ext   = 1'($urandom_range(0, 1));
            rv.sft   = 1'($urandom_range(0, 1));
            rv.tmr   = 1'($urandom_range(0, 1));
            rv.mtvec = $urandom;
            rv.mepc  = $urandom;
            rv.cpc   = $urandom;
            rv.drain = int'($urandom_range(0, 3));
            rv = model(rv);
            apply(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
